bids_n_controller: RTL and testbench
====================================

# bids_n_controller

Parametrised N-player successor of the three-player bid controller. It holds per-player balances and a lock key, and runs multi-cycle bidding rounds with a per-action bid charge, a player mask and affordability checks. It resolves each round to a single winner. It sits between the host command port (C_*) and N player ports, and all outputs are registered.

## Interface
- NUM_PLAYERS, default 4 — player count N, 2..16
- BID_W, default 16 — bid amount width
- BAL_W, default 32 — balance, key, charge and maxBid width
- TIMER_W, default 4 — lockout timer width
- IDX_W, default $clog2(NUM_PLAYERS) — player index width
- clk  in  1 — single clock; all logic is on the rising edge
- reset  in  1 — synchronous, active-high reset
- bid  in  N — per-player bid request
- retract  in  N — per-player retract request
- bid_amt  in  N*BID_W — player i uses bits [i*BID_W +: BID_W]
- C_data  in  BAL_W — command data
- C_op  in  4 — opcode: 0 NOP, 1 Unlock, 2 Lock, 3 LoadPlayer, 4 SetMask, 5 SetTimer, 6 BidCharge; 7–15 are invalid
- C_idx  in  IDX_W — player index for LoadPlayer
- C_start  in  1 — round active while high
- ack  out  N — one-cycle pulse per accepted bid
- p_err  out  2N — per player: 00 ok, 01 round inactive, 10 insufficient funds, 11 invalid or masked
- balance  out  N*BAL_W — committed balances
- win  out  N — one-hot winner, valid while roundOver=1
- ready  out  1 — controller accepting commands
- err  out  3 — 000 ok, 001 bad key, 010 already unlocked, 011 start while unlocked, 100 invalid op, 101 locked out
- roundOver  out  1 — a round result is being held
- maxBid  out  BAL_W — winning total bid

## Operation
- **Registers:** value[N], key, mask[N], timer, bid_cost. Per-round running copies: rbal[N], rtot[N], rchg[N].
- **Reset:** all outputs are 0. value=0, key=0, mask=all ones, timer=all ones, bid_cost=1, state=UNLOCKED.
- **States:** UNLOCKED, LOCKED, ACTIVE, OVER, LOCKOUT.
- **UNLOCKED:**
  - Ops 0, 3, 4, 5 and 6 execute: value[C_idx]=C_data, mask=C_data[N-1:0], timer=C_data[TIMER_W-1:0], bid_cost=C_data. C_idx ≥ N gives err=100 and no write.
  - Lock sets key=C_data and goes to LOCKED.
  - Unlock gives err=010.
  - Ops 7–15 give err=100.
  - C_start=1 gives err=011, ignores C_op and stays in UNLOCKED.
- **LOCKED:**
  - C_start goes to ACTIVE and loads rbal=value, rtot=0, rchg=0.
  - Unlock with C_data==key goes to UNLOCKED.
  - Unlock with C_data!=key gives err=001 and goes to LOCKOUT; the counter loads max(timer,1).
  - Any other non-NOP op gives err=100.
- **LOCKOUT:** ready=0. The counter decrements each cycle and the FSM returns to LOCKED when it reaches 1. Non-NOP commands and C_start give err=101 and are ignored.
- **ACTIVE, each cycle C_start=1, player i:**
  - **Masked (mask[i]=0):** any bid or retract gives p_err=11 and no update.
  - **Bid only:** requires bid_amt+bid_cost ≤ rbal. Then rbal -= amt+cost, rtot += amt, rchg += cost, ack=1. Otherwise p_err=10.
  - **Retract only:** requires amt ≤ rtot and cost ≤ rbal+amt. Then rbal += amt-cost, rtot -= amt, rchg += cost. Otherwise p_err=10.
  - **Bid and retract together:** p_err=11, err=100, no update.
  - C_op is ignored.
- **Round end:** C_start=0 in ACTIVE goes to OVER and commits:
  - Winner = highest rtot among unmasked players; ties go to the lowest index.
  - If all rtot=0 there is no winner: win=0 and maxBid=0.
  - Winner: value=rbal. Losers: value -= rchg (bids are refunded, charges are kept).
- **OVER:**
  - roundOver=1; win and maxBid are held.
  - C_start starts a new round (ACTIVE, running copies reloaded).
  - Unlock follows the LOCKED rules.
  - NOP goes to LOCKED with err=000.
  - Any other op goes to LOCKED with err=100.
- **Widths:** all arithmetic is BAL_W bits with bid_amt zero-extended. The affordability checks guarantee no underflow.
- **p_err=01:** set for a bid or retract made in any state other than ACTIVE.

## Timing
- Inputs are sampled at edge k; responses are visible from edge k+1.
- ack, p_err and err are valid for one cycle, then return to 0.
- ready is 0 during reset and in LOCKOUT, and 1 otherwise.
- The first cycle with C_start=1 in LOCKED only enters ACTIVE; player requests are evaluated from the next cycle.
- balance updates at the edge that enters OVER, together with win, maxBid and roundOver=1.
- roundOver clears on leaving OVER.
- Lockout with timer=T lasts exactly max(T,1) cycles from the bad-key response.
- Reset mid-round or mid-lockout takes effect on the next edge: the round is abandoned and all state returns to reset values.

## Test plan
- **Setup and round:** Load p0=100, p1=50, bid_cost=1, Lock key=0xA5. Round: p0 bids 10, p1 bids 20 in the same cycle, then C_start=0. Expect ack=0b0011, win=0b0010, maxBid=20, balances 99 and 29.
- **Affordability:** p1=5, bid 5 with cost 1 → p_err[1]=10, no ack, balance unchanged.
- **Retract:** bid 30 then retract 20 with cost 2. Expect rtot=10. If winner, balance = 100-30-2+20-2 = 86.
- **Bad key:** timer=3, Unlock with 0x00. Expect err=001, ready=0 for 3 cycles, err=101 on an Unlock during lockout, then LOCKED. A correct key then unlocks.
- **Mask, conflict, tie:** mask=0b1110, p0 bids → p_err=11. p1 bids and retracts together → err=100. p2 and p3 each bid 7 → p2 wins.
- **Misc:** C_start in UNLOCKED → err=011. Reset asserted mid-round → all outputs 0 and value=0 on the next cycle.

Source files
------------

// File: rtl/bids_n_controller.sv
// N-player bid controller: lockable host command port, per-round running
// balances with per-action charges, and single-winner resolution at round end.
module bids_n_controller #(
  parameter int NUM_PLAYERS = 4,
  parameter int BID_W       = 16,
  parameter int BAL_W       = 32,
  parameter int TIMER_W     = 4,
  parameter int IDX_W       = $clog2(NUM_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PLAYERS-1:0]       bid,
  input  logic [NUM_PLAYERS-1:0]       retract,
  input  logic [NUM_PLAYERS*BID_W-1:0] bid_amt,
  input  logic [BAL_W-1:0]             C_data,
  input  logic [3:0]                   C_op,
  input  logic [IDX_W-1:0]             C_idx,
  input  logic                         C_start,
  output logic [NUM_PLAYERS-1:0]       ack,
  output logic [2*NUM_PLAYERS-1:0]     p_err,
  output logic [NUM_PLAYERS*BAL_W-1:0] balance,
  output logic [NUM_PLAYERS-1:0]       win,
  output logic                         ready,
  output logic [2:0]                   err,
  output logic                         roundOver,
  output logic [BAL_W-1:0]             maxBid
);

  localparam int N = NUM_PLAYERS;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_UNLOCK = 4'd1;
  localparam logic [3:0] OP_LOCK   = 4'd2;
  localparam logic [3:0] OP_LOAD   = 4'd3;
  localparam logic [3:0] OP_MASK   = 4'd4;
  localparam logic [3:0] OP_TIMER  = 4'd5;
  localparam logic [3:0] OP_CHARGE = 4'd6;

  localparam logic [2:0] E_OK      = 3'b000;
  localparam logic [2:0] E_KEY     = 3'b001;
  localparam logic [2:0] E_UNLK    = 3'b010;
  localparam logic [2:0] E_START   = 3'b011;
  localparam logic [2:0] E_OP      = 3'b100;
  localparam logic [2:0] E_LOCKOUT = 3'b101;

  localparam logic [1:0] P_OK    = 2'b00;
  localparam logic [1:0] P_IDLE  = 2'b01;
  localparam logic [1:0] P_FUNDS = 2'b10;
  localparam logic [1:0] P_BAD   = 2'b11;

  typedef enum logic [2:0] {
    ST_UNLOCKED = 3'd0,
    ST_LOCKED   = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_OVER     = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BAL_W-1:0]     value_q [N];
  logic [BAL_W-1:0]     value_d [N];
  logic [BAL_W-1:0]     rbal_q [N];
  logic [BAL_W-1:0]     rbal_d [N];
  logic [BAL_W-1:0]     rtot_q [N];
  logic [BAL_W-1:0]     rtot_d [N];
  logic [BAL_W-1:0]     rchg_q [N];
  logic [BAL_W-1:0]     rchg_d [N];
  logic [BAL_W-1:0]     key_q, key_d;
  logic [BAL_W-1:0]     bid_cost_q, bid_cost_d;
  logic [N-1:0]         mask_q, mask_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   cnt_q, cnt_d;

  logic [N-1:0]         ack_q, ack_d;
  logic [2*N-1:0]       p_err_q, p_err_d;
  logic [N-1:0]         win_q, win_d;
  logic                 ready_q, ready_d;
  logic [2:0]           err_q, err_d;
  logic                 round_over_q, round_over_d;
  logic [BAL_W-1:0]     max_bid_q, max_bid_d;

  logic [BAL_W-1:0]     amt_s [N];
  logic [BAL_W-1:0]     best_tot_s;
  logic [N-1:0]         best_oh_s;
  logic                 load_round_s;

  // Zero-extend each player's bid amount to balance width.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      amt_s[i] = BAL_W'(bid_amt[i*BID_W +: BID_W]);
    end
  end

  // Highest running total among unmasked players; strict > keeps the lowest index on ties.
  always_comb begin
    best_tot_s = '0;
    best_oh_s  = '0;
    for (int i = 0; i < N; i++) begin
      if (mask_q[i] && (rtot_q[i] > best_tot_s)) begin
        best_tot_s   = rtot_q[i];
        best_oh_s    = '0;
        best_oh_s[i] = 1'b1;
      end else begin
        best_oh_s = best_oh_s;
      end
    end
  end

  // Next-state, register updates and registered-output values.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    bid_cost_d   = bid_cost_q;
    mask_d       = mask_q;
    timer_d      = timer_q;
    cnt_d        = cnt_q;
    value_d      = value_q;
    rbal_d       = rbal_q;
    rtot_d       = rtot_q;
    rchg_d       = rchg_q;
    ack_d        = '0;
    err_d        = E_OK;
    win_d        = win_q;
    max_bid_d    = max_bid_q;
    round_over_d = round_over_q;
    load_round_s = 1'b0;

    for (int i = 0; i < N; i++) begin
      if ((state_q != ST_ACTIVE) && (bid[i] || retract[i])) begin
        p_err_d[2*i +: 2] = P_IDLE;
      end else begin
        p_err_d[2*i +: 2] = P_OK;
      end
    end

    case (state_q)
      ST_UNLOCKED: begin
        if (C_start) begin
          err_d = E_START;
        end else begin
          case (C_op)
            OP_NOP:    err_d = E_OK;
            OP_UNLOCK: err_d = E_UNLK;
            OP_LOCK: begin
              key_d   = C_data;
              state_d = ST_LOCKED;
            end
            OP_LOAD: begin
              if (int'(C_idx) < N) begin
                for (int i = 0; i < N; i++) begin
                  if (int'(C_idx) == i) begin
                    value_d[i] = C_data;
                  end else begin
                    value_d[i] = value_q[i];
                  end
                end
              end else begin
                err_d = E_OP;
              end
            end
            OP_MASK:   mask_d     = C_data[N-1:0];
            OP_TIMER:  timer_d    = C_data[TIMER_W-1:0];
            OP_CHARGE: bid_cost_d = C_data;
            default:   err_d      = E_OP;
          endcase
        end
      end

      ST_LOCKED: begin
        if (C_start) begin
          state_d      = ST_ACTIVE;
          load_round_s = 1'b1;
        end else begin
          case (C_op)
            OP_NOP: err_d = E_OK;
            OP_UNLOCK: begin
              if (C_data == key_q) begin
                state_d = ST_UNLOCKED;
              end else begin
                err_d   = E_KEY;
                state_d = ST_LOCKOUT;
                cnt_d   = (timer_q == '0) ? TIMER_W'(1'b1) : timer_q;
              end
            end
            default: err_d = E_OP;
          endcase
        end
      end

      ST_LOCKOUT: begin
        if (C_start || (C_op != OP_NOP)) begin
          err_d = E_LOCKOUT;
        end else begin
          err_d = E_OK;
        end
        if (cnt_q <= TIMER_W'(1'b1)) begin
          state_d = ST_LOCKED;
        end else begin
          cnt_d = cnt_q - TIMER_W'(1'b1);
        end
      end

      ST_ACTIVE: begin
        if (C_start) begin
          for (int i = 0; i < N; i++) begin
            if (!mask_q[i]) begin
              if (bid[i] || retract[i]) begin
                p_err_d[2*i +: 2] = P_BAD;
              end else begin
                p_err_d[2*i +: 2] = P_OK;
              end
            end else if (bid[i] && retract[i]) begin
              p_err_d[2*i +: 2] = P_BAD;
              err_d             = E_OP;
            end else if (bid[i]) begin
              if (({1'b0, amt_s[i]} + {1'b0, bid_cost_q}) <= {1'b0, rbal_q[i]}) begin
                rbal_d[i] = rbal_q[i] - amt_s[i] - bid_cost_q;
                rtot_d[i] = rtot_q[i] + amt_s[i];
                rchg_d[i] = rchg_q[i] + bid_cost_q;
                ack_d[i]  = 1'b1;
              end else begin
                p_err_d[2*i +: 2] = P_FUNDS;
              end
            end else if (retract[i]) begin
              // Refund may be needed to cover the charge, so affordability uses rbal+amt.
              if ((amt_s[i] <= rtot_q[i]) &&
                  ({1'b0, bid_cost_q} <= ({1'b0, rbal_q[i]} + {1'b0, amt_s[i]}))) begin
                rbal_d[i] = rbal_q[i] + amt_s[i] - bid_cost_q;
                rtot_d[i] = rtot_q[i] - amt_s[i];
                rchg_d[i] = rchg_q[i] + bid_cost_q;
              end else begin
                p_err_d[2*i +: 2] = P_FUNDS;
              end
            end else begin
              p_err_d[2*i +: 2] = P_OK;
            end
          end
        end else begin
          state_d      = ST_OVER;
          round_over_d = 1'b1;
          win_d        = best_oh_s;
          max_bid_d    = best_tot_s;
          for (int i = 0; i < N; i++) begin
            if (best_oh_s[i]) begin
              value_d[i] = rbal_q[i];
            end else begin
              value_d[i] = value_q[i] - rchg_q[i];
            end
          end
        end
      end

      ST_OVER: begin
        if (C_start) begin
          state_d      = ST_ACTIVE;
          load_round_s = 1'b1;
        end else begin
          case (C_op)
            OP_NOP: state_d = ST_LOCKED;
            OP_UNLOCK: begin
              if (C_data == key_q) begin
                state_d = ST_UNLOCKED;
              end else begin
                err_d   = E_KEY;
                state_d = ST_LOCKOUT;
                cnt_d   = (timer_q == '0) ? TIMER_W'(1'b1) : timer_q;
              end
            end
            default: begin
              err_d   = E_OP;
              state_d = ST_LOCKED;
            end
          endcase
        end
      end

      default: state_d = ST_UNLOCKED;
    endcase

    if (load_round_s) begin
      for (int i = 0; i < N; i++) begin
        rbal_d[i] = value_q[i];
        rtot_d[i] = '0;
        rchg_d[i] = '0;
      end
    end else begin
      load_round_s = 1'b0;
    end

    if (state_d != ST_OVER) begin
      round_over_d = 1'b0;
      win_d        = '0;
      max_bid_d    = '0;
    end else begin
      round_over_d = 1'b1;
    end

    ready_d = (state_d != ST_LOCKOUT);
  end

  // State and registered outputs with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_UNLOCKED;
      key_q        <= '0;
      bid_cost_q   <= BAL_W'(1'b1);
      mask_q       <= '1;
      timer_q      <= '1;
      cnt_q        <= '0;
      for (int i = 0; i < N; i++) begin
        value_q[i] <= '0;
        rbal_q[i]  <= '0;
        rtot_q[i]  <= '0;
        rchg_q[i]  <= '0;
      end
      ack_q        <= '0;
      p_err_q      <= '0;
      win_q        <= '0;
      ready_q      <= 1'b0;
      err_q        <= 3'b000;
      round_over_q <= 1'b0;
      max_bid_q    <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      bid_cost_q   <= bid_cost_d;
      mask_q       <= mask_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      for (int i = 0; i < N; i++) begin
        value_q[i] <= value_d[i];
        rbal_q[i]  <= rbal_d[i];
        rtot_q[i]  <= rtot_d[i];
        rchg_q[i]  <= rchg_d[i];
      end
      ack_q        <= ack_d;
      p_err_q      <= p_err_d;
      win_q        <= win_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      round_over_q <= round_over_d;
      max_bid_q    <= max_bid_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_bal
    assign balance[g*BAL_W +: BAL_W] = value_q[g];
  end

  assign ack       = ack_q;
  assign p_err     = p_err_q;
  assign win       = win_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign roundOver = round_over_q;
  assign maxBid    = max_bid_q;

endmodule

// File: tb/tb_bids_n_controller.sv
// Bench for bids_n_controller: directed scenarios plus randomized rounds scored
// against a per-player arithmetic model of balances, running totals and charges.
module tb_bids_n_controller;
  localparam int N       = 4;
  localparam int BID_W   = 16;
  localparam int BAL_W   = 32;
  localparam int TIMER_W = 4;
  localparam int IDX_W   = 2;

  localparam logic [3:0] NOP = 4'd0, UNLOCK = 4'd1, LOCK = 4'd2, LOAD = 4'd3;
  localparam logic [3:0] MASK = 4'd4, TIMER = 4'd5, CHARGE = 4'd6;
  localparam logic [BAL_W-1:0] KEY = 32'h0000_00A5;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] bid, retract;
  logic [N*BID_W-1:0] bid_amt;
  logic [BAL_W-1:0] C_data;
  logic [3:0] C_op;
  logic [IDX_W-1:0] C_idx;
  logic C_start;
  logic [N-1:0] ack, win;
  logic [2*N-1:0] p_err;
  logic [N*BAL_W-1:0] balance;
  logic ready, roundOver;
  logic [2:0] err;
  logic [BAL_W-1:0] maxBid;

  always #5 clk = ~clk;

  bids_n_controller #(.NUM_PLAYERS(N), .BID_W(BID_W), .BAL_W(BAL_W),
                      .TIMER_W(TIMER_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .bid(bid), .retract(retract), .bid_amt(bid_amt),
    .C_data(C_data), .C_op(C_op), .C_idx(C_idx), .C_start(C_start),
    .ack(ack), .p_err(p_err), .balance(balance), .win(win), .ready(ready),
    .err(err), .roundOver(roundOver), .maxBid(maxBid));

  int n_cmp = 0;
  int n_bad = 0;

  longint mval [N];
  longint rbal [N];
  longint rtot [N];
  longint rchg [N];
  longint mcost;
  logic [N-1:0] mmask;
  logic [N-1:0] e_ack, e_win;
  logic [2*N-1:0] e_perr;
  logic [2:0] e_err;
  longint e_max;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] op, input longint d, input int idx);
    C_op = op; C_data = BAL_W'(d); C_idx = IDX_W'(idx);
    step();
    C_op = NOP; C_data = '0; C_idx = '0;
  endtask

  task automatic load(input int i, input longint v);
    cmd(LOAD, v, i);
    mval[i] = v;
  endtask

  function automatic logic [N*BID_W-1:0] pack4(input int a3, input int a2, input int a1, input int a0);
    return {BID_W'(a3), BID_W'(a2), BID_W'(a1), BID_W'(a0)};
  endfunction

  function automatic logic [N*BAL_W-1:0] exp_bal();
    logic [N*BAL_W-1:0] r;
    for (int i = 0; i < N; i++) r[i*BAL_W +: BAL_W] = mval[i][BAL_W-1:0];
    return r;
  endfunction

  task automatic start_round();
    C_start = 1'b1; bid = '0; retract = '0;
    step();
    for (int i = 0; i < N; i++) begin
      rbal[i] = mval[i]; rtot[i] = 0; rchg[i] = 0;
    end
  endtask

  // One active cycle: apply requests and predict the response from the player rules.
  task automatic play(input logic [N-1:0] b, input logic [N-1:0] r, input logic [N*BID_W-1:0] amts);
    logic [BID_W-1:0] av;
    longint a;
    e_ack = '0; e_perr = '0; e_err = 3'b000;
    for (int i = 0; i < N; i++) begin
      av = amts[i*BID_W +: BID_W];
      a = longint'(av);
      if (!(b[i] || r[i])) continue;
      if (!mmask[i]) e_perr[2*i +: 2] = 2'b11;
      else if (b[i] && r[i]) begin e_perr[2*i +: 2] = 2'b11; e_err = 3'b100; end
      else if (b[i]) begin
        if (a + mcost <= rbal[i]) begin
          rbal[i] -= a + mcost; rtot[i] += a; rchg[i] += mcost; e_ack[i] = 1'b1;
        end else e_perr[2*i +: 2] = 2'b10;
      end else begin
        if (a <= rtot[i] && mcost <= rbal[i] + a) begin
          rbal[i] += a - mcost; rtot[i] -= a; rchg[i] += mcost;
        end else e_perr[2*i +: 2] = 2'b10;
      end
    end
    bid = b; retract = r; bid_amt = amts; C_start = 1'b1;
    step();
    bid = '0; retract = '0; bid_amt = '0;
  endtask

  task automatic end_round();
    longint best;
    best = 0; e_win = '0;
    for (int i = 0; i < N; i++)
      if (mmask[i] && rtot[i] > best) begin best = rtot[i]; e_win = '0; e_win[i] = 1'b1; end
    e_max = best;
    for (int i = 0; i < N; i++)
      if (e_win[i]) mval[i] = rbal[i]; else mval[i] -= rchg[i];
    C_start = 1'b0; bid = '0; retract = '0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; bid = '0; retract = '0; bid_amt = '0;
    C_op = NOP; C_data = '0; C_idx = '0; C_start = 1'b0;
    step(); step();
    n_cmp++; if ({ack, p_err, win, ready, err, roundOver} !== '0) begin
      n_bad++; $display("FAIL reset_ctl: got %h want 0", {ack, p_err, win, ready, err, roundOver}); end
    n_cmp++; if (balance !== '0 || maxBid !== '0) begin
      n_bad++; $display("FAIL reset_data: balance %h maxBid %0d want 0", balance, maxBid); end
    reset = 1'b0;
    step();
    n_cmp++; if (ready !== 1'b1 || err !== 3'b000) begin
      n_bad++; $display("FAIL reset_exit: ready %b err %b want 1/000", ready, err); end
    for (int i = 0; i < N; i++) mval[i] = 0;
    mcost = 1; mmask = '1;
  endtask

  task automatic test_setup_round();
    load(0, 100); load(1, 50);
    cmd(CHARGE, 1, 0); mcost = 1;
    cmd(LOCK, KEY, 0);
    n_cmp++; if (err !== 3'b000 || balance !== exp_bal()) begin
      n_bad++; $display("FAIL setup: err %b balance %h want 000/%h", err, balance, exp_bal()); end
    start_round();
    play(4'b0011, 4'b0000, pack4(0, 0, 20, 10));
    n_cmp++; if (ack !== 4'b0011 || p_err !== 8'h00) begin
      n_bad++; $display("FAIL round1_ack: ack %b p_err %b want 0011/0", ack, p_err); end
    end_round();
    n_cmp++; if (roundOver !== 1'b1 || win !== 4'b0010 || maxBid !== 32'd20) begin
      n_bad++; $display("FAIL round1_result: ro %b win %b max %0d want 1/0010/20", roundOver, win, maxBid); end
    n_cmp++; if (balance !== {32'd0, 32'd0, 32'd29, 32'd99}) begin
      n_bad++; $display("FAIL round1_bal: got %h want 99,29", balance); end
    cmd(NOP, 0, 0);
    n_cmp++; if (roundOver !== 1'b0 || win !== 4'b0000 || err !== 3'b000) begin
      n_bad++; $display("FAIL over_exit: ro %b win %b err %b want 0/0/000", roundOver, win, err); end
  endtask

  task automatic test_affordability();
    cmd(UNLOCK, KEY, 0);
    load(1, 5);
    cmd(LOCK, KEY, 0);
    start_round();
    play(4'b0010, 4'b0000, pack4(0, 0, 5, 0));
    n_cmp++; if (ack !== 4'b0000 || p_err !== 8'b0000_1000) begin
      n_bad++; $display("FAIL afford: ack %b p_err %b want 0000/00001000", ack, p_err); end
    end_round();
    n_cmp++; if (win !== 4'b0000 || maxBid !== 32'd0 || balance !== {32'd0, 32'd0, 32'd5, 32'd99}) begin
      n_bad++; $display("FAIL no_winner: win %b max %0d bal %h", win, maxBid, balance); end
    cmd(NOP, 0, 0);
  endtask

  task automatic test_retract();
    cmd(UNLOCK, KEY, 0);
    load(0, 100);
    cmd(CHARGE, 2, 0); mcost = 2;
    cmd(LOCK, KEY, 0);
    start_round();
    play(4'b0001, 4'b0000, pack4(0, 0, 0, 30));
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL retract_bid: ack %b want 0001", ack); end
    play(4'b0000, 4'b0001, pack4(0, 0, 0, 20));
    n_cmp++; if (ack !== 4'b0000 || p_err !== 8'h00) begin
      n_bad++; $display("FAIL retract_ok: ack %b p_err %b want 0/0", ack, p_err); end
    end_round();
    n_cmp++; if (win !== 4'b0001 || maxBid !== 32'd10 || balance !== {32'd0, 32'd0, 32'd5, 32'd86}) begin
      n_bad++; $display("FAIL retract_result: win %b max %0d bal %h want 0001/10/86", win, maxBid, balance); end
    cmd(NOP, 0, 0);
  endtask

  task automatic test_bad_key();
    cmd(UNLOCK, KEY, 0);
    cmd(TIMER, 3, 0);
    cmd(LOCK, KEY, 0);
    cmd(UNLOCK, 0, 0);
    n_cmp++; if (err !== 3'b001 || ready !== 1'b0) begin
      n_bad++; $display("FAIL badkey: err %b ready %b want 001/0", err, ready); end
    cmd(UNLOCK, KEY, 0);
    n_cmp++; if (err !== 3'b101 || ready !== 1'b0) begin
      n_bad++; $display("FAIL lockout_cmd: err %b ready %b want 101/0", err, ready); end
    step();
    n_cmp++; if (ready !== 1'b0 || err !== 3'b000) begin
      n_bad++; $display("FAIL lockout_3rd: ready %b err %b want 0/000", ready, err); end
    step();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL lockout_end: ready %b want 1", ready); end
    cmd(UNLOCK, KEY, 0);
    cmd(UNLOCK, KEY, 0);
    n_cmp++; if (err !== 3'b010) begin n_bad++; $display("FAIL good_key: err %b want 010", err); end
    cmd(TIMER, 0, 0);
    cmd(LOCK, KEY, 0);
    cmd(UNLOCK, 1, 0);
    step();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL timer0: ready %b want 1", ready); end
    cmd(UNLOCK, KEY, 0);
  endtask

  task automatic test_mask_conflict_tie();
    cmd(MASK, 32'b1110, 0); mmask = 4'b1110;
    for (int i = 0; i < N; i++) load(i, 100);
    cmd(CHARGE, 1, 0); mcost = 1;
    cmd(LOCK, KEY, 0);
    start_round();
    play(4'b0011, 4'b0010, pack4(0, 0, 3, 5));
    n_cmp++; if (p_err !== 8'b0000_1111 || err !== 3'b100 || ack !== 4'b0000) begin
      n_bad++; $display("FAIL mask_conflict: p_err %b err %b ack %b want 00001111/100/0", p_err, err, ack); end
    play(4'b1100, 4'b0000, pack4(7, 7, 0, 0));
    n_cmp++; if (ack !== 4'b1100) begin n_bad++; $display("FAIL tie_ack: ack %b want 1100", ack); end
    end_round();
    n_cmp++; if (win !== 4'b0100 || maxBid !== 32'd7 || balance !== {32'd99, 32'd92, 32'd100, 32'd100}) begin
      n_bad++; $display("FAIL tie_result: win %b max %0d bal %h", win, maxBid, balance); end
    cmd(UNLOCK, KEY, 0);
    n_cmp++; if (err !== 3'b000 || roundOver !== 1'b0) begin
      n_bad++; $display("FAIL over_unlock: err %b ro %b want 000/0", err, roundOver); end
    cmd(UNLOCK, KEY, 0);
    n_cmp++; if (err !== 3'b010) begin n_bad++; $display("FAIL over_unlocked: err %b want 010", err); end
  endtask

  task automatic test_misc();
    C_start = 1'b1;
    cmd(LOCK, KEY, 0);
    C_start = 1'b0;
    n_cmp++; if (err !== 3'b011) begin n_bad++; $display("FAIL start_unlocked: err %b want 011", err); end
    cmd(UNLOCK, KEY, 0);
    n_cmp++; if (err !== 3'b010) begin n_bad++; $display("FAIL still_unlocked: err %b want 010", err); end
    cmd(4'd9, 0, 0);
    n_cmp++; if (err !== 3'b100) begin n_bad++; $display("FAIL invalid_op: err %b want 100", err); end
    bid = 4'b0101;
    step();
    bid = '0;
    n_cmp++; if (p_err !== 8'b0001_0001 || ack !== 4'b0000) begin
      n_bad++; $display("FAIL idle_bid: p_err %b ack %b want 00010001/0", p_err, ack); end
    cmd(LOCK, KEY, 0);
    cmd(MASK, 32'hF, 0);
    n_cmp++; if (err !== 3'b100) begin n_bad++; $display("FAIL locked_op: err %b want 100", err); end
  endtask

  task automatic test_random_rounds();
    logic [N-1:0] b, r;
    logic [N*BID_W-1:0] amts;
    cmd(UNLOCK, KEY, 0);
    mmask = N'($urandom_range(1, 15));
    cmd(MASK, longint'(mmask), 0);
    for (int i = 0; i < N; i++) load(i, longint'($urandom_range(60, 300)));
    mcost = longint'($urandom_range(0, 3));
    cmd(CHARGE, mcost, 0);
    cmd(LOCK, KEY, 0);
    for (int rnd = 0; rnd < 12; rnd++) begin
      start_round();
      for (int c = 0; c < int'($urandom_range(1, 6)); c++) begin
        b = N'($urandom);
        r = N'($urandom);
        if ($urandom_range(0, 7) != 0) r = r & ~b;
        for (int i = 0; i < N; i++) amts[i*BID_W +: BID_W] = BID_W'($urandom_range(0, 40));
        play(b, r, amts);
        n_cmp++; if (ack !== e_ack || p_err !== e_perr || err !== e_err) begin
          n_bad++; $display("FAIL rand_play r%0d: ack %b p_err %b err %b want %b/%b/%b",
                            rnd, ack, p_err, err, e_ack, e_perr, e_err); end
      end
      end_round();
      n_cmp++; if (win !== e_win || maxBid !== e_max[BAL_W-1:0] || balance !== exp_bal()) begin
        n_bad++; $display("FAIL rand_end r%0d: win %b max %0d bal %h want %b/%0d/%h",
                          rnd, win, maxBid, balance, e_win, e_max, exp_bal()); end
      if (rnd % 2 == 0) cmd(NOP, 0, 0);
    end
    cmd(NOP, 0, 0);
  endtask

  task automatic test_reset_midround();
    start_round();
    play(4'b1111, 4'b0000, pack4(1, 1, 1, 1));
    bid = 4'b1111; bid_amt = pack4(1, 1, 1, 1); C_start = 1'b1; reset = 1'b1;
    step();
    n_cmp++; if ({ack, p_err, win, ready, err, roundOver} !== '0 || balance !== '0 || maxBid !== '0) begin
      n_bad++; $display("FAIL reset_mid: ctl %h bal %h max %0d want 0",
                        {ack, p_err, win, ready, err, roundOver}, balance, maxBid); end
    reset = 1'b0; bid = '0; bid_amt = '0; C_start = 1'b0;
    for (int i = 0; i < N; i++) mval[i] = 0;
    mcost = 1; mmask = '1;
    step();
    n_cmp++; if (ready !== 1'b1 || balance !== '0) begin
      n_bad++; $display("FAIL reset_mid_exit: ready %b bal %h want 1/0", ready, balance); end
    load(0, 10); load(3, 10);
    cmd(LOCK, 0, 0);
    start_round();
    play(4'b1001, 4'b0000, pack4(10, 0, 0, 9));
    n_cmp++; if (ack !== 4'b0001 || p_err !== 8'b1000_0000) begin
      n_bad++; $display("FAIL reset_defaults: ack %b p_err %b want 0001/10000000", ack, p_err); end
  endtask

  initial begin
    test_reset();
    test_setup_round();
    test_affordability();
    test_retract();
    test_bad_key();
    test_mask_conflict_tie();
    test_misc();
    test_random_rounds();
    test_reset_midround();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
